// File: rtl/ram_result_reader.sv
// Scans RAM[0..N_WORDS-1] after the Fibonacci sequencer finishes and streams each word out over valid/ready, tagged with its address.
// Define RESULT_CHECK_EN to add the recurrence checker (err/err_addr); otherwise err and err_addr are tied to 0.
module ram_result_reader #(
  parameter int N_WORDS = 32,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_ram_raddr,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_idx,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPT,
    S_SEND,
    S_FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_WORDS - 1);
  localparam logic [2:0]        WAIT_INIT = 3'(RAM_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [2:0]        r_wait;
  logic              w_last;
  logic              w_accept;

  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = o_out_valid && i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_wait == 3'd0) w_next = S_CAPT;
      S_CAPT:  w_next = S_SEND;
      S_SEND:  if (w_accept) w_next = w_last ? S_FIN : S_ISSUE;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The read address only moves at scan start and after a handshake, so ram_dout stays stable through WAIT/CAPT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_wait      <= '0;
      o_ram_raddr <= '0;
      o_out_data  <= '0;
      o_out_idx   <= '0;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx       <= '0;
            o_ram_raddr <= '0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
          end
        end
        S_ISSUE: r_wait <= WAIT_INIT;
        S_WAIT: begin
          if (r_wait != 3'd0) r_wait <= r_wait - 3'd1;
        end
        S_CAPT: begin
          o_out_data  <= i_ram_dout;
          o_out_idx   <= r_idx;
          o_out_valid <= 1'b1;
        end
        S_SEND: begin
          if (w_accept) begin
            o_out_valid <= 1'b0;
            if (!w_last) begin
              r_idx       <= r_idx + 1'b1;
              o_ram_raddr <= r_idx + 1'b1;
            end
          end
        end
        S_FIN: begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RESULT_CHECK_EN
  logic [DATA_W-1:0] r_prev1;
  logic [DATA_W-1:0] r_prev2;
  logic [DATA_W-1:0] w_sum;

  // Sum wraps at DATA_W bits on purpose; only the first mismatch address is kept.
  assign w_sum = r_prev1 + r_prev2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev1    <= '0;
      r_prev2    <= '0;
      o_err      <= 1'b0;
      o_err_addr <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      o_err      <= 1'b0;
      o_err_addr <= '0;
    end else if (r_state == S_CAPT) begin
      r_prev2 <= r_prev1;
      r_prev1 <= i_ram_dout;
      if (r_idx >= ADDR_W'(2) && i_ram_dout != w_sum && !o_err) begin
        o_err      <= 1'b1;
        o_err_addr <= r_idx;
      end
    end
  end
`else
  assign o_err      = 1'b0;
  assign o_err_addr = '0;
`endif

endmodule

// File: tb/tb_ram_result_reader.sv
// Self-checking bench for ram_result_reader: a latency-accurate RAM model plus a reference model that derives the
// expected stream and first recurrence mismatch straight from the RAM contents.
module tb_ram_result_reader;

  localparam int N_WORDS = 32;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int RAM_LAT = 2;
  localparam int BUDGET  = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] ramRaddr;
  logic [DATA_W-1:0] ramDout;
  logic [DATA_W-1:0] outData;
  logic [ADDR_W-1:0] outIdx;
  logic              outValid;
  logic              outReady;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] errAddr;

  logic [DATA_W-1:0] mem  [64];
  logic [DATA_W-1:0] pipe [RAM_LAT];

  int                errors = 0;
  int                checks = 0;
  logic [DATA_W-1:0] gotData[$];
  logic [ADDR_W-1:0] gotIdx[$];
  int                doneCycle;

  ram_result_reader #(
    .N_WORDS(N_WORDS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RAM_LAT(RAM_LAT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .o_ram_raddr(ramRaddr),
    .i_ram_dout (ramDout),
    .o_out_data (outData),
    .o_out_idx  (outIdx),
    .o_out_valid(outValid),
    .i_out_ready(outReady),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_err_addr (errAddr)
  );

  always #5 clk = ~clk;

  // Read port with RAM_LAT registered stages between address and data.
  always @(posedge clk) begin
    pipe[0] <= mem[ramRaddr];
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ramDout = pipe[RAM_LAT-1];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs for one cycle; returns 1 time unit after the edge that sampled them.
  task automatic applyStimulus(input logic s, input logic r, input logic rdy);
    start    = s;
    rst      = r;
    outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  function automatic void loadFib(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    mem[0] = a;
    mem[1] = b;
    for (int i = 2; i < 64; i++) mem[i] = mem[i-1] + mem[i-2];
  endfunction

  // {err, err_addr} the design should report for the current RAM contents.
  function automatic logic [ADDR_W:0] refErr();
`ifdef RESULT_CHECK_EN
    for (int n = 2; n < N_WORDS; n++) begin
      logic [DATA_W-1:0] s;
      s = mem[n-1] + mem[n-2];
      if (mem[n] !== s) return {1'b1, ADDR_W'(n)};
    end
`endif
    return '0;
  endfunction

  // readyMode: 0 = always ready, 1 = ready one cycle in three, 2 = random ready.
  task automatic runScan(input int readyMode, input bit startAgain, input int rstIdx, output bit wasReset);
    bit                prevPend;
    bit                restarted;
    bit                rdy;
    bit                st;
    logic [DATA_W-1:0] pData;
    logic [ADDR_W-1:0] pIdx;
    int                cyc;
    gotData.delete();
    gotIdx.delete();
    doneCycle = -1;
    wasReset  = 1'b0;
    prevPend  = 1'b0;
    restarted = 1'b0;
    pData     = '0;
    pIdx      = '0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    cyc = 0;
    checkOutput("busyAfterStart", 64'(busy), 64'(1));
    checkOutput("doneClearedByStart", 64'(done), 64'(0));
    while (!done && cyc < BUDGET) begin
      if (prevPend)
        checkOutput("holdStable", 64'({outValid, outData, outIdx}), 64'({1'b1, pData, pIdx}));
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      st = 1'b0;
      if (startAgain && !restarted && outValid && outIdx == ADDR_W'(5)) begin
        st        = 1'b1;
        restarted = 1'b1;
      end
      if (rstIdx >= 0 && outValid && outIdx == ADDR_W'(rstIdx)) begin
        applyStimulus(1'b0, 1'b1, 1'b0);
        wasReset = 1'b1;
        return;
      end
      if (outValid && rdy) begin
        gotData.push_back(outData);
        gotIdx.push_back(outIdx);
      end
      prevPend = outValid && !rdy;
      pData    = outData;
      pIdx     = outIdx;
      applyStimulus(st, 1'b0, rdy);
      cyc++;
    end
    checkOutput("doneWithinBudget", 64'(cyc < BUDGET), 64'(1));
    doneCycle = cyc;
  endtask

  task automatic verifyScan(input string tag);
    logic [ADDR_W:0] e;
    e = refErr();
    checkOutput({tag, ".count"}, 64'(gotData.size()), 64'(N_WORDS));
    for (int i = 0; i < gotData.size() && i < N_WORDS; i++) begin
      checkOutput($sformatf("%s.data[%0d]", tag, i), 64'(gotData[i]), 64'(mem[i]));
      checkOutput($sformatf("%s.idx[%0d]", tag, i), 64'(gotIdx[i]), 64'(i));
    end
    checkOutput({tag, ".done"}, 64'(done), 64'(1));
    checkOutput({tag, ".busy"}, 64'(busy), 64'(0));
    checkOutput({tag, ".valid"}, 64'(outValid), 64'(0));
    checkOutput({tag, ".err"}, 64'(err), 64'(e[ADDR_W]));
    checkOutput({tag, ".errAddr"}, 64'(errAddr), 64'(e[ADDR_W-1:0]));
  endtask

  initial begin
    bit wr;
    rst      = 1'b1;
    start    = 1'b0;
    outReady = 1'b0;

    // Reset coinciding with start: reset must win.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("rstWinsBusy", 64'(busy), 64'(0));
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rst.raddr", 64'(ramRaddr), 64'(0));
    checkOutput("rst.data", 64'(outData), 64'(0));
    checkOutput("rst.idx", 64'(outIdx), 64'(0));
    checkOutput("rst.valid", 64'(outValid), 64'(0));
    checkOutput("rst.busy", 64'(busy), 64'(0));
    checkOutput("rst.done", 64'(done), 64'(0));
    checkOutput("rst.err", 64'(err), 64'(0));
    checkOutput("rst.errAddr", 64'(errAddr), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle.readyIgnored", 64'(outValid), 64'(0));

    loadFib(32'd1, 32'd1);
    runScan(0, 1'b0, -1, wr);
    verifyScan("fib");
    checkOutput("fib.last", 64'(gotData.size() == N_WORDS ? gotData[N_WORDS-1] : '0), 64'h213D05);
    checkOutput("fib.doneLatency", 64'(doneCycle), 64'(N_WORDS * (RAM_LAT + 3) + 1));

    runScan(1, 1'b0, -1, wr);
    verifyScan("throttle");

    loadFib(32'd1, 32'd1);
    mem[10] = 32'hDEADBEEF;
    runScan(0, 1'b0, -1, wr);
    verifyScan("corrupt");

    loadFib(32'h80000000, 32'h80000000);
    runScan(0, 1'b0, -1, wr);
    verifyScan("wrap");

    for (int t = 0; t < 3; t++) begin
      loadFib($urandom, $urandom);
      if ($urandom_range(0, 1) == 1) mem[$urandom_range(2, N_WORDS - 1)] = $urandom;
      runScan(2, 1'b0, -1, wr);
      verifyScan($sformatf("random%0d", t));
    end

    loadFib(32'd1, 32'd1);
    runScan(0, 1'b1, -1, wr);
    verifyScan("startWhileBusy");

    // Reset while word 7 waits in SEND, then a clean rescan.
    runScan(0, 1'b0, 7, wr);
    checkOutput("midRst.taken", 64'(wr), 64'(1));
    checkOutput("midRst.words", 64'(gotData.size()), 64'(7));
    checkOutput("midRst.valid", 64'(outValid), 64'(0));
    checkOutput("midRst.busy", 64'(busy), 64'(0));
    checkOutput("midRst.done", 64'(done), 64'(0));
    checkOutput("midRst.raddr", 64'(ramRaddr), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("midRst.staysIdle", 64'({busy, outValid}), 64'(0));
    runScan(0, 1'b0, -1, wr);
    verifyScan("rescan");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_result_reader.md
Name: ram_result_reader

Overview:
- Downstream consumer of the Fibonacci control sequencer.
- After the sequencer finishes writing the sequence into data RAM, this block scans RAM[0..N_WORDS-1] through the RAM read port and streams each word out over a valid/ready interface, tagged with its address.
- It also checks the recurrence RAM[n] = RAM[n-1] + RAM[n-2] (mod 2^DATA_W) and flags the first mismatch.

Parameters:
- N_WORDS, 32, number of words scanned; addresses 0..N_WORDS-1; legal range 3..64.
- ADDR_W, 6, RAM address width.
- DATA_W, 32, RAM word width.
- RAM_LAT, 2, cycles from ram_raddr change to valid ram_dout; legal range 1..7.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a scan (driven when the sequencer reaches its finish state).
- ram_raddr  out  ADDR_W  RAM read address.
- ram_dout  in  DATA_W  RAM read data, valid RAM_LAT cycles after the address.
- out_data  out  DATA_W  streamed word.
- out_idx  out  ADDR_W  address of out_data.
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  consumer accepts when high together with out_valid.
- busy  out  1  scan in progress.
- done  out  1  sticky; scan complete.
- err  out  1  sticky; recurrence mismatch seen.
- err_addr  out  ADDR_W  address of first mismatch.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - ram_raddr=0, out_data=0, out_idx=0.
  - out_valid=0, busy=0, done=0, err=0, err_addr=0.
  - FSM=IDLE; internal idx=0, wait counter=0, prev1=prev2=0.
- States: IDLE, ISSUE, WAIT, CAPT, SEND, FIN.
- IDLE:
  - start=1: idx<=0, ram_raddr<=0, busy<=1, done<=0, err<=0, err_addr<=0, go to ISSUE.
  - start=0: stay.
- ISSUE: load wait counter with RAM_LAT-1, go to WAIT.
- WAIT: decrement the counter; at 0 go to CAPT. ram_dout is sampled exactly RAM_LAT cycles after ram_raddr was updated.
- CAPT:
  - out_data<=ram_dout, out_idx<=idx, out_valid<=1.
  - Shift history: prev2<=prev1, prev1<=ram_dout.
  - Run the recurrence check (see Optional Feature).
  - Go to SEND.
- SEND:
  - Hold out_valid, out_data and out_idx stable until out_ready=1.
  - On the handshake cycle, out_valid<=0.
  - If idx==N_WORDS-1: go to FIN.
  - Otherwise: idx<=idx+1, ram_raddr<=idx+1, go to ISSUE.
- FIN: busy<=0, done<=1, go to IDLE. done stays high until the next accepted start.
- out_ready while out_valid=0 is ignored.
- Minimum cost per word with out_ready tied high: RAM_LAT+3 cycles.
- start while busy=1 is ignored; the scan continues unaffected.
- start in the same cycle as rst: reset wins.
- rst mid-scan: all outputs return to reset values on the next edge. A pending out_valid is dropped, with no completion handshake.
- Arithmetic: the sum prev1+prev2 is truncated to DATA_W bits, so wrap-around is legal and not an error.
- idx never exceeds N_WORDS-1; ram_raddr never addresses beyond the scanned range.

Optional Feature:
- Macro: RESULT_CHECK_EN.
- Defined:
  - In CAPT with idx>=2, compare ram_dout against prev1+prev2 (DATA_W-bit).
  - On mismatch with err=0: err<=1, err_addr<=idx.
  - Later mismatches do not change err_addr.
  - The scan always runs to completion.
- Undefined:
  - Comparator and prev registers are removed; err and err_addr are tied to 0.
  - Streaming behaviour and timing are identical.

Test Plan:
- RAM preloaded with Fibonacci, RAM[0]=RAM[1]=1; start pulse; out_ready=1 -> 32 transfers, idx 0..31, RAM[31]=2178309 (0x213D05); done=1, busy=0, err=0; done rises 32*(RAM_LAT+3)+1 cycles after start.
- Same data; out_ready toggles 1-of-3 cycles -> out_data/out_idx held stable while out_valid=1 and out_ready=0; no word lost or duplicated; order 0..31.
- Fibonacci preload with RAM[10] corrupted to 0xDEADBEEF (RESULT_CHECK_EN defined) -> err=1, err_addr=10 (RAM[11] and RAM[12] also mismatch, but err_addr stays 10); all 32 words still streamed. With the macro undefined -> err=0.
- RAM[0]=RAM[1]=0x80000000 and the remaining words generated with 32-bit wrap (RAM[2]=0, RAM[3]=0x80000000, ...) -> err=0.
- start pulsed again at idx=5 -> ignored; the scan still emits exactly 32 words.
- rst asserted for 1 cycle while in SEND at idx=7 -> next cycle: out_valid=0, busy=0, done=0, FSM IDLE. A following start rescans from idx 0.
